// File: rtl/membus_pkg.sv
// Types and parameter defaults for the I/D memory-port arbiter.
package membus_pkg;
  import svconfig::*;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
  typedef enum logic {SEL_I = 1'b0, SEL_D = 1'b1} master_sel_t;

  localparam int          DEF_ADDR_WIDTH   = 32;
  localparam int          DEF_DATA_WIDTH   = 32;
  localparam logic [31:0] DEF_EXIT_ADDR    = TEST_EXIT_ADDR;
  localparam logic [31:0] DEF_EXIT_SUCCESS = TEST_WDATA_SUCCESS;
endpackage

// File: rtl/svconfig.sv
// Platform-wide constants shared by the core and its test harness.
package svconfig;
  localparam logic [31:0] TEST_EXIT_ADDR     = 32'h0000_1000;
  localparam logic [31:0] TEST_WDATA_SUCCESS = 32'd1;
endpackage

// File: rtl/membus_arbiter_rr_sel2.sv
// Two-way round-robin picker; a held (stalled) request overrides arbitration.
// Latency: combinational. Backpressure: none, selection only.
// Ready gating is left to the caller.
module rr_sel2
  import membus_pkg::*;
(
  input  logic        i_valid,
  input  logic        d_valid,
  input  master_sel_t last_grant,
  input  logic        lock_valid,
  input  master_sel_t lock_sel,
  output master_sel_t sel
);

  always_comb begin
    sel = SEL_I;
    if (lock_valid) begin
      sel = lock_sel;
    end else if (i_valid && d_valid) begin
      sel = (last_grant == SEL_I) ? SEL_D : SEL_I;
    end else if (d_valid) begin
      sel = SEL_D;
    end
  end

endmodule

// File: rtl/membus_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D); optional exit snoop under TEST_EXIT_MONITOR_EN.
// Latency: request and response both pass through combinationally (0 cycles).
// Backpressure: one outstanding txn; loser and stalled cycles see ready=0, new issue allowed in response cycle.
module membus_arbiter
  import membus_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] EXIT_ADDR    = ADDR_WIDTH'(DEF_EXIT_ADDR),
  parameter logic [DATA_WIDTH-1:0] EXIT_SUCCESS = DATA_WIDTH'(DEF_EXIT_SUCCESS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_valid,
  output logic                    d_ready,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic                    d_wen,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    test_done,
  output logic                    test_success
);

  arb_state_t  state_q, state_d;
  master_sel_t last_grant_q, last_grant_d;
  master_sel_t lock_sel_q, lock_sel_d;
  master_sel_t sel;
  logic        lock_valid_q, lock_valid_d;
  logic        can_issue, sel_valid, accept, sel_is_d;

  rr_sel2 u_rr_sel2 (
    .i_valid    (i_valid),
    .d_valid    (d_valid),
    .last_grant (last_grant_q),
    .lock_valid (lock_valid_q),
    .lock_sel   (lock_sel_q),
    .sel        (sel)
  );

  // The response cycle frees the port, so a new request may issue alongside it.
  assign can_issue = (state_q == IDLE) || mem_rvalid;
  assign sel_is_d  = (sel == SEL_D);
  assign sel_valid = sel_is_d ? d_valid : i_valid;
  assign mem_valid = can_issue && sel_valid;
  assign accept    = mem_valid && mem_ready;

  assign i_ready   = !sel_is_d && mem_ready && can_issue;
  assign d_ready   =  sel_is_d && mem_ready && can_issue;

  assign mem_addr  = sel_is_d ? d_addr : i_addr;
  assign mem_wen   = sel_is_d && d_wen;
  assign mem_wdata = sel_is_d ? d_wdata : '0;
  assign mem_wmask = sel_is_d ? d_wmask : '0;

  assign i_rvalid  = mem_rvalid && (state_q == BUSY_I);
  assign d_rvalid  = mem_rvalid && (state_q == BUSY_D);
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= SEL_D;
      lock_valid_q <= 1'b0;
      lock_sel_q   <= SEL_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_valid_q <= lock_valid_d;
      lock_sel_q   <= lock_sel_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_valid_d = lock_valid_q;
    lock_sel_d   = lock_sel_q;
    if (mem_rvalid && state_q != IDLE) begin
      state_d = IDLE;
    end
    if (accept) begin
      state_d      = sel_is_d ? BUSY_D : BUSY_I;
      last_grant_d = sel;
      lock_valid_d = 1'b0;
    end else if (mem_valid) begin
      // Stalled: pin the presented master so a late competitor cannot swap fields.
      lock_valid_d = 1'b1;
      lock_sel_d   = sel;
    end
  end

  rvalid_in_idle_a: assert property (@(posedge clk) disable iff (!rst)
    !(mem_rvalid && state_q == IDLE));

`ifdef TEST_EXIT_MONITOR_EN
  logic done_q, success_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q    <= 1'b0;
      success_q <= 1'b0;
    end else if (!done_q && accept && sel_is_d && d_wen && d_addr == EXIT_ADDR) begin
      done_q    <= 1'b1;
      success_q <= (d_wdata == EXIT_SUCCESS);
    end
  end

  assign test_done    = done_q;
  assign test_success = success_q;
`else
  localparam logic unused_exit_cfg = ^{EXIT_ADDR, EXIT_SUCCESS};
  assign test_done    = 1'b0;
  assign test_success = 1'b0;
`endif

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter with a per-cycle transaction-level reference.
module tb_membus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ready, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_valid, d_ready, d_wen, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wmask;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        test_done, test_success;

  int n_chk = 0;
  int n_err = 0;
  logic auto_resp = 1'b0;
  logic man_rvalid = 1'b0;

  always #5 clk = ~clk;

  membus_arbiter dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen),
    .d_wdata(d_wdata), .d_wmask(d_wmask), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .test_done(test_done), .test_success(test_success)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Zero-wait memory: answers every accepted request on the following cycle.
  initial begin
    logic acc_seen;
    mem_rvalid = 1'b0;
    forever begin
      @(negedge clk);
      acc_seen = mem_valid && mem_ready && rst;
      @(posedge clk);
      #2;
      mem_rvalid = auto_resp ? acc_seen : man_rvalid;
    end
  end

  // Reference: who owns the port, who won last, and which master is pinned by a stall.
  initial begin
    int owner, last, held, pick;
    logic free, e_mv, m_done, m_succ;
    owner = -1; last = 1; held = -1; m_done = 0; m_succ = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        owner = -1; last = 1; held = -1; m_done = 0; m_succ = 0;
      end
      free = (owner < 0) || mem_rvalid;
      if (held >= 0)                pick = held;
      else if (i_valid && d_valid)  pick = 1 - last;
      else                          pick = d_valid ? 1 : 0;
      e_mv = free && (pick == 1 ? d_valid : i_valid);

      chk("m_mem_valid", {31'd0, mem_valid}, {31'd0, e_mv});
      chk("m_i_ready", {31'd0, i_ready}, {31'd0, free && mem_ready && pick == 0});
      chk("m_d_ready", {31'd0, d_ready}, {31'd0, free && mem_ready && pick == 1});
      chk("m_i_rvalid", {31'd0, i_rvalid}, {31'd0, mem_rvalid && owner == 0});
      chk("m_d_rvalid", {31'd0, d_rvalid}, {31'd0, mem_rvalid && owner == 1});
      if (i_rvalid) chk("m_i_rdata", i_rdata, mem_rdata);
      if (d_rvalid) chk("m_d_rdata", d_rdata, mem_rdata);
      if (e_mv) begin
        chk("m_mem_addr", mem_addr, pick == 1 ? d_addr : i_addr);
        chk("m_mem_wen", {31'd0, mem_wen}, {31'd0, pick == 1 && d_wen});
        chk("m_mem_wdata", mem_wdata, pick == 1 ? d_wdata : 32'd0);
        chk("m_mem_wmask", {28'd0, mem_wmask}, {28'd0, pick == 1 ? d_wmask : 4'd0});
      end
`ifdef TEST_EXIT_MONITOR_EN
      chk("m_test_done", {31'd0, test_done}, {31'd0, m_done});
      chk("m_test_success", {31'd0, test_success}, {31'd0, m_succ});
`else
      chk("m_test_done", {31'd0, test_done}, 32'd0);
      chk("m_test_success", {31'd0, test_success}, 32'd0);
`endif

      if (rst) begin
        if (mem_rvalid && owner >= 0) owner = -1;
        if (e_mv && mem_ready) begin
          if (pick == 1 && d_wen && d_addr == 32'h1000 && !m_done) begin
            m_done = 1'b1;
            m_succ = (d_wdata == 32'd1);
          end
          owner = pick; last = pick; held = -1;
        end else if (e_mv) begin
          held = pick;
        end
      end
    end
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: bench did not finish, got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; i_valid = 0; i_addr = 0; d_valid = 0; d_addr = 0; d_wen = 0;
    d_wdata = 0; d_wmask = 0; mem_ready = 0; mem_rdata = 0;

    // Reset state
    sample();
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("rst_test_done", {31'd0, test_done}, 32'd0);

    // Single fetch
    next_cyc();
    rst = 1'b1; mem_ready = 1'b1; auto_resp = 1'b1;
    i_valid = 1'b1; i_addr = 32'h100;
    sample();
    chk("fetch_i_ready", {31'd0, i_ready}, 32'd1);
    chk("fetch_mem_addr", mem_addr, 32'h100);
    next_cyc();
    i_valid = 1'b0; mem_rdata = 32'hDEADBEEF;
    sample();
    chk("fetch_i_rvalid", {31'd0, i_rvalid}, 32'd1);
    chk("fetch_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("fetch_d_rvalid", {31'd0, d_rvalid}, 32'd0);

    // Stall lock: last grant was I, so without the lock D would win once it appears
    next_cyc();
    i_valid = 1'b1; i_addr = 32'h200; mem_ready = 1'b0;
    sample();
    chk("stall0_addr", mem_addr, 32'h200);
    chk("stall0_i_ready", {31'd0, i_ready}, 32'd0);
    next_cyc();
    d_valid = 1'b1; d_addr = 32'h300; d_wen = 1'b0;
    sample();
    chk("stall1_addr", mem_addr, 32'h200);
    chk("stall1_d_ready", {31'd0, d_ready}, 32'd0);
    next_cyc();
    sample();
    chk("stall2_addr", mem_addr, 32'h200);
    next_cyc();
    mem_ready = 1'b1;
    sample();
    chk("stall3_i_ready", {31'd0, i_ready}, 32'd1);
    chk("stall3_addr", mem_addr, 32'h200);
    next_cyc();
    i_valid = 1'b0; mem_rdata = 32'h1111_2222;
    sample();
    chk("stall4_i_rvalid", {31'd0, i_rvalid}, 32'd1);
    chk("stall4_d_ready", {31'd0, d_ready}, 32'd1);
    chk("stall4_addr", mem_addr, 32'h300);

    // Back-to-back: new D request in D's response cycle
    next_cyc();
    d_addr = 32'h304; d_wen = 1'b1; d_wdata = 32'hCAFE; d_wmask = 4'h3;
    sample();
    chk("b2b_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("b2b_d_ready", {31'd0, d_ready}, 32'd1);
    chk("b2b_mem_wen", {31'd0, mem_wen}, 32'd1);
    next_cyc();
    d_valid = 1'b0;
    sample();
    chk("b2b_busy_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    next_cyc();
    sample();
    chk("b2b_quiet_d_rvalid", {31'd0, d_rvalid}, 32'd0);

    // Reset mid-transaction, stray response while in reset
    next_cyc();
    d_valid = 1'b1; d_addr = 32'h400; d_wen = 1'b0;
    sample();
    chk("rmid_d_ready", {31'd0, d_ready}, 32'd1);
    next_cyc();
    d_valid = 1'b0; rst = 1'b0; auto_resp = 1'b0;
    sample();
    chk("rmid_mem_valid", {31'd0, mem_valid}, 32'd0);
    next_cyc();
    man_rvalid = 1'b1;
    sample();
    chk("rmid_stray_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("rmid_stray_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    next_cyc();
    rst = 1'b1; man_rvalid = 1'b0; auto_resp = 1'b1;
    sample();
    chk("rmid_after_d_rvalid", {31'd0, d_rvalid}, 32'd0);

    // Tie after reset: I, D, I, D
    next_cyc();
    i_valid = 1'b1; i_addr = 32'h500;
    d_valid = 1'b1; d_addr = 32'h600; d_wen = 1'b1; d_wdata = 32'h55; d_wmask = 4'hF;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("tie_i_ready", {31'd0, i_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("tie_d_ready", {31'd0, d_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("tie_mem_wen", {31'd0, mem_wen}, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("tie_mem_addr", mem_addr, (k % 2 == 0) ? 32'h500 : 32'h600);
      if (k < 3) next_cyc();
    end
    next_cyc();
    i_valid = 1'b0; d_valid = 1'b0;
    sample();
    chk("tie_last_d_rvalid", {31'd0, d_rvalid}, 32'd1);

    // Exit monitor: first exit write latches, later one is ignored
    next_cyc();
    d_valid = 1'b1; d_addr = 32'h1000; d_wen = 1'b1; d_wdata = 32'd1;
    sample();
    chk("exit1_d_ready", {31'd0, d_ready}, 32'd1);
    chk("exit1_forwarded", mem_addr, 32'h1000);
    next_cyc();
    d_valid = 1'b0;
    sample();
`ifdef TEST_EXIT_MONITOR_EN
    chk("exit1_done", {31'd0, test_done}, 32'd1);
    chk("exit1_success", {31'd0, test_success}, 32'd1);
`else
    chk("exit1_done", {31'd0, test_done}, 32'd0);
    chk("exit1_success", {31'd0, test_success}, 32'd0);
`endif
    next_cyc();
    d_valid = 1'b1; d_wdata = 32'd3;
    sample();
    chk("exit2_d_ready", {31'd0, d_ready}, 32'd1);
    next_cyc();
    d_valid = 1'b0;
    next_cyc();
    sample();
`ifdef TEST_EXIT_MONITOR_EN
    chk("exit2_done", {31'd0, test_done}, 32'd1);
    chk("exit2_success", {31'd0, test_success}, 32'd1);
`else
    chk("exit2_done", {31'd0, test_done}, 32'd0);
    chk("exit2_success", {31'd0, test_success}, 32'd0);
`endif

    next_cyc();
    sample();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
